float_div: RTL and testbench

- Sequential IEEE-754 single-precision divider: out = num_1 / num_2.
- Companion (inverse operation) to the float multiplier in the FP execution slot.
- Iterative restoring mantissa division, one quotient bit per clock; start/busy/done handshake; fixed latency for all operand classes so the VLIW scheduler can issue statically.

---
 rtl/float_pkg.sv | 22 ++
 rtl/fdiv_core.sv | 56 +++++
 rtl/float_div.sv | 144 ++++++++++++++
 tb/tb_float_div.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared constants and state type for the FP divide slot.
// Rounding mode is selected in float_div by FDIV_ROUND_NEAREST_EN.
package float_pkg;

   localparam int EXP_W   = 8;
   localparam int MAN_W   = 23;
   localparam int WORD_W  = 1 + EXP_W + MAN_W;
   localparam int BIAS    = 127;
   localparam int Q_W     = MAN_W + 3;
   localparam int CNT_W   = $clog2(Q_W + 1);
   localparam int LATENCY = MAN_W + 5;

   localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;
   localparam logic [WORD_W-1:0] POS_INF = 32'h7F80_0000;

   typedef enum logic [1:0] {
      IDLE,
      DIV,
      NORM
   } fdiv_state_t;

endpackage

// File: rtl/fdiv_core.sv
// Restoring mantissa divider: {1,man_a} / {1,man_b}, one quotient bit per step,
// MSB first (weight 2^0 down to 2^-(Q_W-1)); finished once all Q_W bits are in.
module fdiv_core
   import float_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [MAN_W-1:0] man_a,
   input  logic [MAN_W-1:0] man_b,
   output logic [Q_W-1:0]   q,
   output logic             rem_nz,
   output logic             finished
);

   logic [MAN_W:0]   divisor;
   logic [MAN_W+1:0] rem;
   logic [MAN_W:0]   diff;
   logic             q_bit;
   logic [CNT_W-1:0] cnt;

   // The partial remainder is always below 2*divisor, so the low bits of the
   // subtraction are exact whenever q_bit is set.
   always_comb begin
      q_bit = (rem >= {1'b0, divisor});
      diff  = rem[MAN_W:0] - divisor;
   end

   assign finished = (cnt == CNT_W'(Q_W));
   assign rem_nz   = |rem;

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (step && !finished) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // NOTE: the datapath is not reset; it is always loaded before it is read.
   always_ff @(posedge clk) begin
      if (load) begin
         divisor <= {1'b1, man_b};
         rem     <= {2'b01, man_a};
         q       <= '0;
      end else if (step && !finished) begin
         q   <= {q[Q_W-2:0], q_bit};
         rem <= q_bit ? {diff, 1'b0} : {rem[MAN_W:0], 1'b0};
      end
   end

endmodule

// File: rtl/float_div.sv
// Sequential single-precision divider, out = num_1 / num_2, fixed LATENCY for all inputs.
// Define FDIV_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results truncate.
module float_div
   import float_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WORD_W-1:0] num_1,
   input  logic [WORD_W-1:0] num_2,
   output logic              busy,
   output logic              done,
   output logic [WORD_W-1:0] out
);

   localparam logic signed [EXP_W+1:0] BIAS_S   = (EXP_W+2)'(BIAS);
   localparam logic signed [EXP_W+1:0] EXP_MAX  = (EXP_W+2)'((1 << EXP_W) - 1);
   localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;
   localparam logic signed [EXP_W+1:0] EXP_ONE  = (EXP_W+2)'(1);

   fdiv_state_t state, state_next;

   logic [WORD_W-1:0] op_a, op_b;
   logic              load;
   logic [Q_W-1:0]    q;
   logic              rem_nz, finished;

   logic              sign_a, sign_b, sign;
   logic [EXP_W-1:0]  exp_a, exp_b;
   logic [MAN_W-1:0]  man_a, man_b;
   logic              a_zero, b_zero, a_inf, b_inf, any_nan;

   logic signed [EXP_W+1:0] exp_diff, exp_n, exp_r;
   logic [MAN_W-1:0]        man_t;
   logic [MAN_W:0]          man_r;
   logic                    guard, sticky, round_up;
   logic [WORD_W-1:0]       result;

   assign load = (state == IDLE) && start;

   fdiv_core u_core (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .step     (state == DIV),
      .man_a    (num_1[MAN_W-1:0]),
      .man_b    (num_2[MAN_W-1:0]),
      .q        (q),
      .rem_nz   (rem_nz),
      .finished (finished)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      state_next = state;
      busy       = (state != IDLE);
      case (state)
         IDLE:    if (start) state_next = DIV;
         DIV:     if (finished) state_next = NORM;
         NORM:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (load) begin
         op_a <= num_1;
         op_b <= num_2;
      end
   end

   assign {sign_a, exp_a, man_a} = op_a;
   assign {sign_b, exp_b, man_b} = op_b;
   assign sign    = sign_a ^ sign_b;
   assign a_zero  = (exp_a == '0);
   assign b_zero  = (exp_b == '0);
   assign a_inf   = (&exp_a) && (man_a == '0);
   assign b_inf   = (&exp_b) && (man_b == '0);
   assign any_nan = ((&exp_a) && (man_a != '0)) || ((&exp_b) && (man_b != '0)) ||
                    (a_zero && b_zero) || (a_inf && b_inf);

   // A quotient below 1.0 leaves its leading one at q[Q_W-2], costing one exponent step.
   always_comb begin
      exp_diff = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b});
      if (q[Q_W-1]) begin
         man_t  = q[Q_W-2:2];
         guard  = q[1];
         sticky = q[0] | rem_nz;
         exp_n  = exp_diff + BIAS_S;
      end else begin
         man_t  = q[Q_W-3:1];
         guard  = q[0];
         sticky = rem_nz;
         exp_n  = exp_diff + BIAS_S - EXP_ONE;
      end
   end

`ifdef FDIV_ROUND_NEAREST_EN
   assign round_up = guard & (sticky | man_t[0]);
`else
   logic unused_round;
   assign round_up     = 1'b0;
   assign unused_round = guard | sticky;
`endif

   always_comb begin
      man_r = {1'b0, man_t} + {{MAN_W{1'b0}}, round_up};
      exp_r = man_r[MAN_W] ? exp_n + EXP_ONE : exp_n;
      if (any_nan) begin
         result = QNAN;
      end else if (a_inf || b_zero) begin
         result = POS_INF | {sign, {(WORD_W-1){1'b0}}};
      end else if (a_zero || b_inf) begin
         result = {sign, {(WORD_W-1){1'b0}}};
      end else if (exp_r >= EXP_MAX) begin
         result = POS_INF | {sign, {(WORD_W-1){1'b0}}};
      end else if (exp_r <= EXP_ZERO) begin
         result = {sign, {(WORD_W-1){1'b0}}};
      end else begin
         result = {sign, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done <= 1'b0;
         out  <= '0;
      end else begin
         done <= (state == NORM);
         if (state == NORM) begin
            out <= result;
         end
      end
   end

endmodule

// File: tb/tb_float_div.sv
// Self-checking bench for float_div: directed cases, handshake/reset scenarios and
// random operands against an integer long-division reference model.
module tb_float_div;
   import float_pkg::*;

`ifdef FDIV_ROUND_NEAREST_EN
   localparam logic [31:0] THIRD_Q = 32'h3EAA_AAAB;
   localparam logic [31:0] SIX_5THS_Q = 32'h3F99_999A;
`else
   localparam logic [31:0] THIRD_Q = 32'h3EAA_AAAA;
   localparam logic [31:0] SIX_5THS_Q = 32'h3F99_9999;
`endif

   logic        clk = 1'b0;
   logic        rst, start;
   logic [31:0] num_1, num_2;
   logic        busy, done;
   logic [31:0] out;

   int checks = 0;
   int errors = 0;

   float_div dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .num_1 (num_1),
      .num_2 (num_2),
      .busy  (busy),
      .done  (done),
      .out   (out)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: exact quotient from integer division, then the rounding and range rules.
   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      logic              sign;
      int                ea, eb, e;
      logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      longint unsigned   num, den, qv, rv;
      logic [31:0]       mant;
      logic              g, s, up;
      sign   = a[31] ^ b[31];
      ea     = int'(a[30:23]);
      eb     = int'(b[30:23]);
      a_zero = (ea == 0);
      b_zero = (eb == 0);
      a_nan  = (ea == 255) && (a[22:0] != 0);
      b_nan  = (eb == 255) && (b[22:0] != 0);
      a_inf  = (ea == 255) && (a[22:0] == 0);
      b_inf  = (eb == 255) && (b[22:0] == 0);
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return 32'h7FC0_0000;
      if (a_inf || b_zero) return {sign, 8'hFF, 23'd0};
      if (a_zero || b_inf) return {sign, 31'd0};
      num = {40'd0, 1'b1, a[22:0]};
      num = num << 25;
      den = {40'd0, 1'b1, b[22:0]};
      qv  = num / den;
      rv  = num % den;
      if (qv >= (64'd1 << 25)) begin
         e    = ea - eb + 127;
         mant = 32'(qv >> 2) & 32'h007F_FFFF;
         g    = qv[1];
         s    = qv[0] || (rv != 0);
      end else begin
         e    = ea - eb + 126;
         mant = 32'(qv >> 1) & 32'h007F_FFFF;
         g    = qv[0];
         s    = (rv != 0);
      end
      up = g && (s || mant[0]);
`ifndef FDIV_ROUND_NEAREST_EN
      up = 1'b0;
`endif
      mant = mant + 32'(up);
      if (mant == 32'h0080_0000) begin
         mant = 0;
         e++;
      end
      if (e >= 255) return {sign, 8'hFF, 23'd0};
      if (e <= 0) return {sign, 31'd0};
      return {sign, 8'(e), mant[22:0]};
   endfunction

   function automatic logic [31:0] rand_operand();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 11))
         0: v[30:23] = 8'h00;
         1: v[30:23] = 8'hFF;
         2: v[30:0] = '0;
         3: v[30:0] = {8'hFF, 23'd0};
         4: v[30:23] = 8'($urandom_range(1, 254));
         default: v[30:23] = 8'(97 + $urandom_range(0, 60));
      endcase
      return v;
   endfunction

   // Presents an operation; returns at the negedge just after the sampling edge k.
   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      num_1 = a;
      num_2 = b;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // n = edges after k until done is seen; optionally re-pulses start at edge k+poke_at+1.
   task automatic wait_done(input int poke_at, output int n, output bit busy_ok);
      n       = 0;
      busy_ok = 1'b1;
      while (done !== 1'b1 && n < 100) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (n == poke_at) begin
            start = 1'b1;
            num_1 = 32'h3F80_0000;
            num_2 = 32'h4040_0000;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
      int n;
      bit busy_ok;
      issue(a, b);
      wait_done(-1, n, busy_ok);
      check({tag, "/latency"}, 32'(n), 32'(LATENCY));
      check({tag, "/out"}, out, exp);
      check({tag, "/busy_during"}, 32'(busy_ok), 32'd1);
   endtask

   initial begin
      int          n, n1, n2;
      bit          busy_ok;
      logic [31:0] a, b, o1, o2;

      rst   = 1'b1;
      start = 1'b0;
      num_1 = '0;
      num_2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset/busy", 32'(busy), 32'd0);
      check("reset/done", 32'(done), 32'd0);
      check("reset/out", out, 32'h0);

      // 6.0 / 2.0 with full handshake timing and hold
      issue(32'h40C0_0000, 32'h4000_0000);
      wait_done(-1, n, busy_ok);
      check("six_two/latency", 32'(n), 32'(LATENCY));
      check("six_two/busy_during", 32'(busy_ok), 32'd1);
      check("six_two/busy_clr", 32'(busy), 32'd0);
      check("six_two/out", out, 32'h4040_0000);
      repeat (3) @(negedge clk);
      check("six_two/done_pulse", 32'(done), 32'd0);
      check("six_two/hold", out, 32'h4040_0000);

      run_op("third", 32'h3F80_0000, 32'h4040_0000, THIRD_Q);
      run_op("six_5ths", 32'h3FC0_0000, 32'h3FA0_0000, SIX_5THS_Q);
      run_op("neg_div0", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000);
      run_op("zero_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000);
      run_op("nan_in", 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
      run_op("zero_neg", 32'h0000_0000, 32'hC000_0000, 32'h8000_0000);
      run_op("inf_inf", 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
      run_op("inf_fin", 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);
      run_op("fin_inf", 32'h4000_0000, 32'hFF80_0000, 32'h8000_0000);
      run_op("overflow", 32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000);
      run_op("underflow", 32'h0080_0000, 32'h4000_0000, 32'h0000_0000);
      run_op("denorm_in", 32'h0040_0000, 32'h3F80_0000, 32'h0000_0000);

      // start while busy, with new operands, must be ignored
      issue(32'h40C0_0000, 32'h4000_0000);
      wait_done(4, n, busy_ok);
      check("ignore/latency", 32'(n), 32'(LATENCY));
      check("ignore/out", out, 32'h4040_0000);
      @(negedge clk);
      check("ignore/no_second", 32'(busy), 32'd0);

      // start held high across done: next done follows LATENCY+1 edges later
      @(negedge clk);
      num_1 = 32'h3F80_0000;
      num_2 = 32'h4040_0000;
      start = 1'b1;
      n  = 0;
      n1 = -1;
      n2 = -1;
      o1 = '0;
      o2 = '0;
      while (n2 < 0 && n < 200) begin
         @(negedge clk);
         n++;
         if (done === 1'b1) begin
            if (n1 < 0) begin
               n1 = n;
               o1 = out;
            end else begin
               n2 = n;
               o2 = out;
            end
         end
      end
      start = 1'b0;
      check("b2b/first", 32'(n1), 32'(LATENCY + 1));
      check("b2b/gap", 32'(n2 - n1), 32'(LATENCY + 1));
      check("b2b/out1", o1, THIRD_Q);
      check("b2b/out2", o2, THIRD_Q);
      repeat (2) @(negedge clk);

      // reset in the middle of a division
      issue(32'h40C0_0000, 32'h4000_0000);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst/busy", 32'(busy), 32'd0);
      check("midrst/done", 32'(done), 32'd0);
      check("midrst/out", out, 32'h0);
      run_op("after_rst", 32'h3FC0_0000, 32'hBFA0_0000, SIX_5THS_Q | 32'h8000_0000);

      for (int i = 0; i < 40; i++) begin
         a = rand_operand();
         b = rand_operand();
         issue(a, b);
         wait_done(-1, n, busy_ok);
         check($sformatf("rand%0d/latency", i), 32'(n), 32'(LATENCY));
         check($sformatf("rand%0d/out %h/%h", i, a, b), out, ref_div(a, b));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
